// File: rtl/writeback_commit_unit_l2_pkg.sv
// Shared types for the writeback-commit unit: X->W, completion and commit messages.
// seq_num fields are sized for the widest supported ROB; users keep the low p_seq_num_bits.
package writeback_commit_unit_l2_pkg;

    localparam int unsigned PC_W             = 32;
    localparam int unsigned DATA_W           = 32;
    localparam int unsigned REG_ADDR_W       = 5;
    localparam int unsigned SEQ_NUM_BITS_MAX = 8;

    typedef logic [SEQ_NUM_BITS_MAX-1:0] seq_num_t;

    typedef struct packed {
        logic [PC_W-1:0]       pc;
        seq_num_t              seq_num;
        logic [REG_ADDR_W-1:0] waddr;
        logic [DATA_W-1:0]     wdata;
        logic                  wen;
    } xw_msg_t;

    typedef struct packed {
        seq_num_t              seq_num;
        logic [REG_ADDR_W-1:0] waddr;
        logic [DATA_W-1:0]     wdata;
        logic                  wen;
    } complete_msg_t;

    typedef struct packed {
        logic [PC_W-1:0]       pc;
        seq_num_t              seq_num;
        logic [REG_ADDR_W-1:0] waddr;
        logic [DATA_W-1:0]     wdata;
        logic                  wen;
    } commit_msg_t;

    // ROB payload; the seq_num is implied by the entry index
    typedef struct packed {
        logic [PC_W-1:0]       pc;
        logic [REG_ADDR_W-1:0] waddr;
        logic [DATA_W-1:0]     wdata;
        logic                  wen;
    } rob_entry_t;

endpackage

// File: rtl/writeback_commit_unit_l2_if.sv
// Execute-pipe handshake plus completion/commit notification bundle.
interface writeback_commit_unit_l2_if #(
    parameter int unsigned p_num_pipes    = 1,
    parameter int unsigned p_seq_num_bits = 5
);
    logic [p_num_pipes-1:0]    Ex_val;
    logic [p_num_pipes-1:0]    Ex_rdy;
    logic [31:0]               Ex_pc      [p_num_pipes];
    logic [p_seq_num_bits-1:0] Ex_seq_num [p_num_pipes];
    logic [4:0]                Ex_waddr   [p_num_pipes];
    logic [31:0]               Ex_wdata   [p_num_pipes];
    logic [p_num_pipes-1:0]    Ex_wen;

    logic                      complete_val;
    logic [p_seq_num_bits-1:0] complete_seq_num;
    logic [4:0]                complete_waddr;
    logic [31:0]               complete_wdata;
    logic                      complete_wen;

    logic                      commit_val;
    logic [31:0]               commit_pc;
    logic [p_seq_num_bits-1:0] commit_seq_num;
    logic [4:0]                commit_waddr;
    logic [31:0]               commit_wdata;
    logic                      commit_wen;

    modport master (
        output Ex_val, Ex_pc, Ex_seq_num, Ex_waddr, Ex_wdata, Ex_wen,
        input  Ex_rdy,
        input  complete_val, complete_seq_num, complete_waddr, complete_wdata, complete_wen,
        input  commit_val, commit_pc, commit_seq_num, commit_waddr, commit_wdata, commit_wen
    );

    modport slave (
        input  Ex_val, Ex_pc, Ex_seq_num, Ex_waddr, Ex_wdata, Ex_wen,
        output Ex_rdy,
        output complete_val, complete_seq_num, complete_waddr, complete_wdata, complete_wen,
        output commit_val, commit_pc, commit_seq_num, commit_waddr, commit_wdata, commit_wen
    );
endinterface

// File: rtl/writeback_commit_unit_l2_rob.sv
// wcu_rob: reorder buffer indexed by seq_num with an in-order head pointer.
module wcu_rob
    import writeback_commit_unit_l2_pkg::*;
#(
    parameter int unsigned p_seq_num_bits = 5
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              wr_en,
    input  logic [p_seq_num_bits-1:0]         wr_idx,
    input  rob_entry_t                        wr_entry,
    input  logic                              adv,
    output logic [(1 << p_seq_num_bits)-1:0]  valid,
    output logic [p_seq_num_bits-1:0]         head,
    output logic                              head_valid_c,
    output rob_entry_t                        head_entry_c
);
    localparam int unsigned DEPTH = 1 << p_seq_num_bits;

    rob_entry_t mem [DEPTH];

    // Valid bits and head; the top never writes the slot being retired this cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
            head  <= '0;
        end else begin
            if (adv) begin
                valid[head] <= 1'b0;
                head        <= head + p_seq_num_bits'(1);
            end
            if (wr_en) begin
                valid[wr_idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_entry;
        end
    end

    assign head_valid_c = valid[head];
    assign head_entry_c = mem[head];

endmodule

// File: rtl/writeback_commit_unit_l2.sv
// Writeback-commit unit: fixed-priority accept, same-cycle completion, in-order commit.
// Define WCU_COMMIT_BYPASS_EN to commit an accepted head instruction in its accept cycle.
module writeback_commit_unit_l2
    import writeback_commit_unit_l2_pkg::*;
#(
    parameter int unsigned p_num_pipes    = 1,
    parameter int unsigned p_seq_num_bits = 5
) (
    input logic                        clk,
    input logic                        rst,
    writeback_commit_unit_l2_if.slave  bus
);
    localparam int unsigned DEPTH = 1 << p_seq_num_bits;

    logic [p_num_pipes-1:0]    sel_onehot;
    logic                      sel_found;
    xw_msg_t                   sel_msg;
    logic [p_seq_num_bits-1:0] sel_seq;
    logic [p_num_pipes-1:0]    rdy;
    logic                      accept;
    logic                      bypass;
    logic                      wr_en;
    logic                      adv;
    complete_msg_t             cmp_msg;
    commit_msg_t               cmt_msg;

    logic [DEPTH-1:0]          rob_valid;
    logic [p_seq_num_bits-1:0] head;
    logic                      head_valid_c;
    rob_entry_t                head_entry_c;

    // Lowest-index valid pipe wins; descending scan so the last hit is the lowest
    always_comb begin
        sel_found  = 1'b0;
        sel_onehot = '0;
        sel_msg    = '0;
        for (int p = int'(p_num_pipes) - 1; p >= 0; p--) begin
            if (bus.Ex_val[p]) begin
                sel_found     = 1'b1;
                sel_onehot    = '0;
                sel_onehot[p] = 1'b1;
                sel_msg.pc      = bus.Ex_pc[p];
                sel_msg.seq_num = SEQ_NUM_BITS_MAX'(bus.Ex_seq_num[p]);
                sel_msg.waddr   = bus.Ex_waddr[p];
                sel_msg.wdata   = bus.Ex_wdata[p];
                sel_msg.wen     = bus.Ex_wen[p];
            end
        end
    end

    always_comb begin
        sel_seq = p_seq_num_bits'(sel_msg.seq_num);
        accept  = sel_found && !rob_valid[sel_seq] && !rst;
        rdy     = accept ? sel_onehot : '0;
`ifdef WCU_COMMIT_BYPASS_EN
        bypass  = accept && (sel_seq == head) && !head_valid_c;
`else
        bypass  = 1'b0;
`endif
        wr_en   = accept && !bypass;
        adv     = !rst && (head_valid_c || bypass);

        cmp_msg.seq_num = sel_msg.seq_num;
        cmp_msg.waddr   = sel_msg.waddr;
        cmp_msg.wdata   = sel_msg.wdata;
        cmp_msg.wen     = sel_msg.wen;

        if (bypass) begin
            cmt_msg = commit_msg_t'(sel_msg);
        end else begin
            cmt_msg.pc      = head_entry_c.pc;
            cmt_msg.seq_num = SEQ_NUM_BITS_MAX'(head);
            cmt_msg.waddr   = head_entry_c.waddr;
            cmt_msg.wdata   = head_entry_c.wdata;
            cmt_msg.wen     = head_entry_c.wen;
        end
    end

    wcu_rob #(
        .p_seq_num_bits (p_seq_num_bits)
    ) u_rob (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_idx       (sel_seq),
        .wr_entry     ('{pc: sel_msg.pc, waddr: sel_msg.waddr, wdata: sel_msg.wdata, wen: sel_msg.wen}),
        .adv          (adv),
        .valid        (rob_valid),
        .head         (head),
        .head_valid_c (head_valid_c),
        .head_entry_c (head_entry_c)
    );

    assign bus.Ex_rdy           = rdy;
    assign bus.complete_val     = accept;
    assign bus.complete_seq_num = p_seq_num_bits'(cmp_msg.seq_num);
    assign bus.complete_waddr   = cmp_msg.waddr;
    assign bus.complete_wdata   = cmp_msg.wdata;
    assign bus.complete_wen     = cmp_msg.wen;
    assign bus.commit_val       = adv;
    assign bus.commit_pc        = cmt_msg.pc;
    assign bus.commit_seq_num   = p_seq_num_bits'(cmt_msg.seq_num);
    assign bus.commit_waddr     = cmt_msg.waddr;
    assign bus.commit_wdata     = cmt_msg.wdata;
    assign bus.commit_wen       = cmt_msg.wen;

    // Upper seq_num bits of the shared structs are zero padding
    logic unused_seq_hi;
    assign unused_seq_hi = ^{sel_msg.seq_num, cmp_msg.seq_num, cmt_msg.seq_num};

    // Line trace: accepted seq_num > committed seq_num; level > 1 adds waddr
    function automatic string trace(input int level);
        string acc;
        string com;
        acc = bus.complete_val ? $sformatf("%0d", bus.complete_seq_num) : "  ";
        com = bus.commit_val   ? $sformatf("%0d", bus.commit_seq_num)   : "  ";
        if (level > 1) begin
            if (bus.complete_val) acc = $sformatf("%s:r%0d", acc, bus.complete_waddr);
            if (bus.commit_val)   com = $sformatf("%s:r%0d", com, bus.commit_waddr);
        end
        return $sformatf("%s > %s", acc, com);
    endfunction

endmodule

// File: tb/tb_writeback_commit_unit_l2.sv
// Directed bench for writeback_commit_unit_l2 (default build, 3-bit seq_num, 1- and 2-pipe instances).
module tb_writeback_commit_unit_l2;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   ncommits;

    writeback_commit_unit_l2_if #(.p_num_pipes(1), .p_seq_num_bits(3)) if1 ();
    writeback_commit_unit_l2_if #(.p_num_pipes(2), .p_seq_num_bits(3)) if2 ();

    writeback_commit_unit_l2 #(.p_num_pipes(1), .p_seq_num_bits(3)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1.slave)
    );

    writeback_commit_unit_l2 #(.p_num_pipes(2), .p_seq_num_bits(3)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (if2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic drive1(input logic v, input logic [31:0] pc, input logic [2:0] seq,
                          input logic [4:0] wa, input logic [31:0] wd, input logic we);
        if1.Ex_val[0]     = v;
        if1.Ex_pc[0]      = pc;
        if1.Ex_seq_num[0] = seq;
        if1.Ex_waddr[0]   = wa;
        if1.Ex_wdata[0]   = wd;
        if1.Ex_wen[0]     = we;
    endtask

    task automatic drive2(input int p, input logic v, input logic [31:0] pc, input logic [2:0] seq,
                          input logic [4:0] wa, input logic [31:0] wd, input logic we);
        if2.Ex_val[p]     = v;
        if2.Ex_pc[p]      = pc;
        if2.Ex_seq_num[p] = seq;
        if2.Ex_waddr[p]   = wa;
        if2.Ex_wdata[p]   = wd;
        if2.Ex_wen[p]     = we;
    endtask

    task automatic idle_all();
        drive1(1'b0, 32'h0, 3'd0, 5'd0, 32'h0, 1'b0);
        drive2(0, 1'b0, 32'h0, 3'd0, 5'd0, 32'h0, 1'b0);
        drive2(1, 1'b0, 32'h0, 3'd0, 5'd0, 32'h0, 1'b0);
    endtask

    task automatic do_reset();
        idle_all();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Completion check on instance d (0: 1-pipe, 1: 2-pipe); fields only when valid expected
    task automatic chk_cmp(input string tag, input bit d, input logic v, input logic [2:0] seq,
                           input logic [4:0] wa, input logic [31:0] wd, input logic we);
        chk({tag, "_val"}, d ? if2.complete_val : if1.complete_val, v);
        if (v) begin
            chk({tag, "_seq"},   d ? if2.complete_seq_num : if1.complete_seq_num, seq);
            chk({tag, "_waddr"}, d ? if2.complete_waddr   : if1.complete_waddr,   wa);
            chk({tag, "_wdata"}, d ? if2.complete_wdata   : if1.complete_wdata,   wd);
            chk({tag, "_wen"},   d ? if2.complete_wen     : if1.complete_wen,     we);
        end
    endtask

    task automatic chk_cmt(input string tag, input bit d, input logic v, input logic [31:0] pc,
                           input logic [2:0] seq, input logic [4:0] wa, input logic [31:0] wd,
                           input logic we);
        chk({tag, "_val"}, d ? if2.commit_val : if1.commit_val, v);
        if (v) begin
            chk({tag, "_pc"},    d ? if2.commit_pc      : if1.commit_pc,      pc);
            chk({tag, "_seq"},   d ? if2.commit_seq_num : if1.commit_seq_num, seq);
            chk({tag, "_waddr"}, d ? if2.commit_waddr   : if1.commit_waddr,   wa);
            chk({tag, "_wdata"}, d ? if2.commit_wdata   : if1.commit_wdata,   wd);
            chk({tag, "_wen"},   d ? if2.commit_wen     : if1.commit_wen,     we);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        idle_all();

        // Reset: a valid offer is refused and nothing is notified
        tick();
        drive1(1'b1, 32'h100, 3'd0, 5'd3, 32'h1, 1'b1);
        drive2(0, 1'b1, 32'h100, 3'd0, 5'd3, 32'h1, 1'b1);
        sample();
        chk("rst_rdy1", 64'(if1.Ex_rdy), 64'd0);
        chk("rst_rdy2", 64'(if2.Ex_rdy), 64'd0);
        chk("rst_cmp_val", 64'(if1.complete_val), 64'd0);
        chk("rst_cmt_val", 64'(if1.commit_val), 64'd0);
        tick();
        rst = 1'b0;
        idle_all();
        sample();
        chk("post_rst_cmt_val", 64'(if1.commit_val), 64'd0);
        tick();

        // Single instruction: same-cycle completion, commit one cycle later
        drive1(1'b1, 32'h200, 3'd0, 5'd1, 32'hdeadbeef, 1'b1);
        sample();
        chk("t1_rdy", 64'(if1.Ex_rdy), 64'd1);
        chk_cmp("t1_cmp", 1'b0, 1'b1, 3'd0, 5'd1, 32'hdeadbeef, 1'b1);
        chk_cmt("t1_cmt_early", 1'b0, 1'b0, 32'h0, 3'd0, 5'd0, 32'h0, 1'b0);
        tick();
        idle_all();
        sample();
        chk_cmp("t1_cmp_idle", 1'b0, 1'b0, 3'd0, 5'd0, 32'h0, 1'b0);
        chk_cmt("t1_cmt", 1'b0, 1'b1, 32'h200, 3'd0, 5'd1, 32'hdeadbeef, 1'b1);
        tick();
        sample();
        chk_cmt("t1_cmt_after", 1'b0, 1'b0, 32'h0, 3'd0, 5'd0, 32'h0, 1'b0);
        tick();

        // In-order 0..3 back-to-back: one completion and one commit per cycle
        do_reset();
        for (int k = 0; k <= 4; k++) begin
            if (k < 4) drive1(1'b1, 32'h1000 + 32'(4 * k), 3'(k), 5'(k + 1), 32'ha0 + 32'(k), 1'b1);
            else       idle_all();
            sample();
            chk_cmp($sformatf("t2_cmp%0d", k), 1'b0, k < 4, 3'(k), 5'(k + 1), 32'ha0 + 32'(k), 1'b1);
            chk_cmt($sformatf("t2_cmt%0d", k), 1'b0, k > 0, 32'h1000 + 32'(4 * (k - 1)), 3'(k - 1),
                    5'(k), 32'ha0 + 32'(k - 1), 1'b1);
            tick();
        end
        sample();
        chk("t2_cmt_end", 64'(if1.commit_val), 64'd0);
        tick();

        // Out-of-order 2,0,1 with an occupied-slot refusal in between
        do_reset();
        drive1(1'b1, 32'h302, 3'd2, 5'd7, 32'h22, 1'b1);
        sample();
        chk_cmp("t3_cmp2", 1'b0, 1'b1, 3'd2, 5'd7, 32'h22, 1'b1);
        chk_cmt("t3_c0", 1'b0, 1'b0, 32'h0, 3'd0, 5'd0, 32'h0, 1'b0);
        tick();
        drive1(1'b1, 32'h3ff, 3'd2, 5'd9, 32'hbad, 1'b1);
        sample();
        chk("t3_busy_rdy", 64'(if1.Ex_rdy), 64'd0);
        chk_cmp("t3_busy_cmp", 1'b0, 1'b0, 3'd0, 5'd0, 32'h0, 1'b0);
        chk_cmt("t3_c1", 1'b0, 1'b0, 32'h0, 3'd0, 5'd0, 32'h0, 1'b0);
        tick();
        drive1(1'b1, 32'h300, 3'd0, 5'd5, 32'h00, 1'b1);
        sample();
        chk_cmp("t3_cmp0", 1'b0, 1'b1, 3'd0, 5'd5, 32'h00, 1'b1);
        chk_cmt("t3_c2", 1'b0, 1'b0, 32'h0, 3'd0, 5'd0, 32'h0, 1'b0);
        tick();
        drive1(1'b1, 32'h301, 3'd1, 5'd6, 32'h11, 1'b1);
        sample();
        chk_cmp("t3_cmp1", 1'b0, 1'b1, 3'd1, 5'd6, 32'h11, 1'b1);
        chk_cmt("t3_cmt0", 1'b0, 1'b1, 32'h300, 3'd0, 5'd5, 32'h00, 1'b1);
        tick();
        idle_all();
        sample();
        chk_cmt("t3_cmt1", 1'b0, 1'b1, 32'h301, 3'd1, 5'd6, 32'h11, 1'b1);
        tick();
        sample();
        chk_cmt("t3_cmt2", 1'b0, 1'b1, 32'h302, 3'd2, 5'd7, 32'h22, 1'b1);
        tick();
        sample();
        chk("t3_cmt_end", 64'(if1.commit_val), 64'd0);
        tick();

        // Wrap: seq 0..7 then 0..2, wen=0 throughout
        do_reset();
        ncommits = 0;
        for (int k = 0; k <= 11; k++) begin
            if (k < 11) drive1(1'b1, 32'h400 + 32'(4 * k), 3'(k % 8), 5'(k), 32'h5500 + 32'(k), 1'b0);
            else        idle_all();
            sample();
            if (if1.commit_val) ncommits++;
            if (k < 11) chk($sformatf("t4_rdy%0d", k), 64'(if1.Ex_rdy), 64'd1);
            chk_cmp($sformatf("t4_cmp%0d", k), 1'b0, k < 11, 3'(k % 8), 5'(k), 32'h5500 + 32'(k), 1'b0);
            chk_cmt($sformatf("t4_cmt%0d", k), 1'b0, k > 0, 32'h400 + 32'(4 * (k - 1)),
                    3'((k + 7) % 8), 5'(k - 1), 32'h5500 + 32'(k - 1), 1'b0);
            tick();
        end
        chk("t4_ncommits", 64'(ncommits), 64'd11);
        sample();
        chk("t4_cmt_end", 64'(if1.commit_val), 64'd0);
        tick();

        // Two pipes: pipe0 (seq 1) beats pipe1 (seq 0); commits still 0 then 1
        do_reset();
        drive2(0, 1'b1, 32'h501, 3'd1, 5'd9, 32'h91, 1'b1);
        drive2(1, 1'b1, 32'h500, 3'd0, 5'd8, 32'h80, 1'b1);
        sample();
        chk("t5_rdy_a", 64'(if2.Ex_rdy), 64'd1);
        chk_cmp("t5_cmp_a", 1'b1, 1'b1, 3'd1, 5'd9, 32'h91, 1'b1);
        chk_cmt("t5_c0", 1'b1, 1'b0, 32'h0, 3'd0, 5'd0, 32'h0, 1'b0);
        tick();
        drive2(0, 1'b0, 32'h0, 3'd0, 5'd0, 32'h0, 1'b0);
        sample();
        chk("t5_rdy_b", 64'(if2.Ex_rdy), 64'd2);
        chk_cmp("t5_cmp_b", 1'b1, 1'b1, 3'd0, 5'd8, 32'h80, 1'b1);
        chk_cmt("t5_c1", 1'b1, 1'b0, 32'h0, 3'd0, 5'd0, 32'h0, 1'b0);
        tick();
        idle_all();
        sample();
        chk_cmt("t5_cmt0", 1'b1, 1'b1, 32'h500, 3'd0, 5'd8, 32'h80, 1'b1);
        tick();
        sample();
        chk_cmt("t5_cmt1", 1'b1, 1'b1, 32'h501, 3'd1, 5'd9, 32'h91, 1'b1);
        tick();
        sample();
        chk("t5_cmt_end", 64'(if2.commit_val), 64'd0);
        tick();

        // Reset mid-operation drops pending seq 1; a fresh seq 0 commits from head 0
        do_reset();
        drive1(1'b1, 32'h601, 3'd1, 5'd2, 32'h61, 1'b1);
        sample();
        chk_cmp("t6_cmp1", 1'b0, 1'b1, 3'd1, 5'd2, 32'h61, 1'b1);
        tick();
        idle_all();
        sample();
        chk("t6_wait_cmt", 64'(if1.commit_val), 64'd0);
        tick();
        rst = 1'b1;
        drive1(1'b1, 32'h6ff, 3'd0, 5'd4, 32'h66, 1'b1);
        sample();
        chk("t6_rst_rdy", 64'(if1.Ex_rdy), 64'd0);
        chk("t6_rst_cmp", 64'(if1.complete_val), 64'd0);
        chk("t6_rst_cmt", 64'(if1.commit_val), 64'd0);
        tick();
        rst = 1'b0;
        idle_all();
        sample();
        chk("t6_no_cmt1", 64'(if1.commit_val), 64'd0);
        tick();
        drive1(1'b1, 32'h600, 3'd0, 5'd3, 32'h60, 1'b1);
        sample();
        chk_cmp("t6_cmp0", 1'b0, 1'b1, 3'd0, 5'd3, 32'h60, 1'b1);
        chk_cmt("t6_c_early", 1'b0, 1'b0, 32'h0, 3'd0, 5'd0, 32'h0, 1'b0);
        tick();
        idle_all();
        sample();
        chk_cmt("t6_cmt0", 1'b0, 1'b1, 32'h600, 3'd0, 5'd3, 32'h60, 1'b1);
        tick();
        sample();
        chk("t6_cmt_end", 64'(if1.commit_val), 64'd0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/writeback_commit_unit_l2.md
# writeback_commit_unit_l2

Reordering writeback-commit unit for the out-of-order pipeline. It accepts finished instructions from `p_num_pipes` execute pipes in any order and emits a completion notification for each one as it writes back. A reorder buffer indexed by sequence number then emits commit notifications in strict program (sequence-number) order. It sits between the execute pipes (X) and the register file / rename / retirement logic.

## Interface
- `p_num_pipes`, default 1: number of X→W input pipes.
- `p_seq_num_bits`, default 5: sequence-number width; ROB depth = 2^`p_seq_num_bits`.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `Ex_val[p]` in 1 each: pipe p offers an instruction.
- `Ex_rdy[p]` out 1 each: pipe p accepted this cycle.
- `Ex_pc[p]` in 32: instruction PC.
- `Ex_seq_num[p]` in `p_seq_num_bits`: program-order tag.
- `Ex_waddr[p]` in 5: destination architectural register.
- `Ex_wdata[p]` in 32: result value.
- `Ex_wen[p]` in 1: instruction writes a register.
- `complete_val`, `complete_seq_num`, `complete_waddr`, `complete_wdata`, `complete_wen` out (1/`p_seq_num_bits`/5/32/1): completion notification, no backpressure.
- `commit_val`, `commit_pc`, `commit_seq_num`, `commit_waddr`, `commit_wdata`, `commit_wen` out (1/32/`p_seq_num_bits`/5/32/1): commit notification, no backpressure.
- Line-trace function `trace(level)` returning a string with the accepted and committed seq_nums.

## Operation
- Arbitration: at most one pipe is accepted per cycle, using fixed priority (lowest index wins). `Ex_rdy[p]` = p is the highest-priority valid pipe AND ROB entry `Ex_seq_num[p]` is free. All other rdy signals are 0.
- Completion: on a handshake, `complete_*` presents that pipe's seq_num/waddr/wdata/wen combinationally in the same cycle, with `complete_val`=1. `complete_val`=0 otherwise, and the data fields are don't-care.
- ROB: on a handshake, entry[seq_num] gets {valid=1, pc, waddr, wdata, wen} at the clock edge.
- Commit: the head pointer starts at 0. If entry[head] is valid, `commit_*` presents that entry with `commit_val`=1. At the edge the entry is cleared and head increments modulo 2^`p_seq_num_bits`, wrapping from 2^n−1 to 0.
- At most one commit per cycle.
- `wen`=0 instructions pass through both notifications unchanged, with `wen`=0.
- An accept and a commit of different entries in the same cycle are both performed. Accepting into a slot being freed that cycle is not allowed: the slot still reads valid, so rdy=0.

## Timing
- Reset: head=0 and all ROB valid bits are cleared. During reset all `Ex_rdy`=0, `complete_val`=0, `commit_val`=0. A reset mid-operation discards all pending entries.
- Completion latency is 0 cycles from the handshake.
- Commit latency is ≥1 cycle after acceptance in the default build. An in-order stream commits at one instruction per cycle.
- Out-of-order arrivals wait in the ROB until every older seq_num has committed.

## Configuration
- `WCU_COMMIT_BYPASS_EN`:
  - Defined: if the accepted seq_num equals head and entry[head] is invalid, it commits in the same cycle as acceptance. Commit is driven from the input, and the entry is not written.
  - Undefined (default): there is no bypass, and every commit comes from the ROB register.

## Structure
- Shared package holds:
  - X→W message struct {pc, seq_num, waddr, wdata, wen}.
  - Complete message struct.
  - Commit message struct.
  - The structs are parameterized by seq_num width.
- Sub-module `wcu_rob`: storage plus head pointer, with a write port, a head read port, and a commit-advance input. Arbitration and completion stay in the top level.

## Test plan
- `p_seq_num_bits`=3, 1 pipe, default build. Send pc 0x200, seq 0, waddr 1, wdata 0xdeadbeef, wen 1 → complete {0,1,0xdeadbeef,1} in the same cycle; commit {0x200,0,1,0xdeadbeef,1} on the next cycle.
- In-order seq 0,1,2,3 back-to-back → complete order 0,1,2,3 and commit order 0,1,2,3, one per cycle.
- Out-of-order: send seq 2, then 0, then 1 → complete order 2,0,1; commit order 0,1,2, and commit of 0 does not occur before seq 0 arrives.
- Wrap: send seq 0–7 then 0–2, all wen=0 → 11 commits in order, with head wrapping 7→0 and wen=0 preserved.
- 2 pipes, both valid with seq 1 (pipe0) and seq 0 (pipe1) → pipe0 accepted first, pipe1 next cycle; commits 0 then 1.
- Accept seq 1, then assert `rst` before seq 0 arrives → no commit of 1; after reset head=0, and a fresh seq 0 commits normally.
